// File: rtl/arb_pkg.sv
// Shared definitions for the IF/MEM single-port SRAM arbiter: FSM states,
// owner encoding and the default access length.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam int DEFAULT_WAIT_CYCLES = 4;

    // Counter must hold WAIT_CYCLES-1 with one bit of headroom.
    function automatic int cnt_width(input int wait_cycles);
        return $clog2(wait_cycles) + 1;
    endfunction

endpackage

// File: rtl/access_timer.sv
// Loadable down-counter that measures one SRAM access; done is high once
// the count has reached zero (the last BUSY cycle).
module access_timer
    import arb_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CNT_W = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle single-port SRAM between instruction fetch and
// data access; MEM has fixed priority and each access ends with a ready pulse.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              freeze_if,
    output logic              freeze_pipe
);

    state_t            state_reg;
    logic              owner_reg;
    logic              sram_en_reg;
    logic              sram_we_reg;
    logic [ADDR_W-1:0] sram_addr_reg;
    logic [DATA_W-1:0] sram_wdata_reg;
    logic              ready_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] mem_rdata_reg;

    logic mem_req;
    logic timer_load;
    logic timer_en;
    logic timer_done;

    assign mem_req    = mem_rd_en | mem_wr_en;
    assign timer_load = (state_reg == IDLE) && (mem_req || if_req);
    assign timer_en   = (state_reg == BUSY);

    access_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(timer_load),
        .en  (timer_en),
        .done(timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_IF;
            sram_en_reg    <= 1'b0;
            sram_we_reg    <= 1'b0;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
            ready_reg      <= 1'b0;
            if_rdata_reg   <= '0;
            mem_rdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b0;
                    if (mem_req) begin
                        state_reg      <= BUSY;
                        owner_reg      <= OWN_MEM;
                        sram_en_reg    <= 1'b1;
                        sram_we_reg    <= mem_wr_en;
                        sram_addr_reg  <= mem_addr;
                        sram_wdata_reg <= mem_wdata;
                    end else if (if_req) begin
                        state_reg     <= BUSY;
                        owner_reg     <= OWN_IF;
                        sram_en_reg   <= 1'b1;
                        sram_we_reg   <= 1'b0;
                        sram_addr_reg <= if_addr;
                    end
                end
                BUSY: begin
                    // A taken branch abandons only a fetch; data accesses always finish.
                    if ((owner_reg == OWN_IF) && if_flush) begin
                        state_reg   <= IDLE;
                        sram_en_reg <= 1'b0;
                        sram_we_reg <= 1'b0;
                    end else if (timer_done) begin
                        if (!sram_we_reg) begin
                            if (owner_reg == OWN_MEM) begin
                                mem_rdata_reg <= sram_rdata;
                            end else begin
                                if_rdata_reg <= sram_rdata;
                            end
                        end
                        state_reg   <= RESP;
                        sram_en_reg <= 1'b0;
                        sram_we_reg <= 1'b0;
                        ready_reg   <= 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                end
                default: begin
                    state_reg   <= IDLE;
                    sram_en_reg <= 1'b0;
                    sram_we_reg <= 1'b0;
                    ready_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign sram_en    = sram_en_reg;
    assign sram_we    = sram_we_reg;
    assign sram_addr  = sram_addr_reg;
    assign sram_wdata = sram_wdata_reg;
    assign if_rdata   = if_rdata_reg;
    assign mem_rdata  = mem_rdata_reg;

    // A flush in the response cycle still suppresses the fetch completion.
    assign if_ready    = ready_reg & (owner_reg == OWN_IF) & ~if_flush;
    assign mem_ready   = ready_reg & (owner_reg == OWN_MEM);
    assign freeze_pipe = mem_req & ~mem_ready;
    assign freeze_if   = (if_req & ~if_ready) | freeze_pipe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-by-cycle vector table for the arbiter plus a hand-written sequence
// for MEM priority over a waiting fetch.
module tb_mem_port_arbiter;

    localparam logic [31:0] D10   = 32'hE3A01005;
    localparam logic [31:0] D20   = 32'h11112222;
    localparam logic [31:0] D30   = 32'h33333333;
    localparam logic [31:0] D80   = 32'h80808080;
    localparam logic [31:0] D100  = 32'hCAFEF00D;
    localparam logic [31:0] DBEEF = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        freeze_if;
    logic        freeze_pipe;

    logic [31:0] tb_mem [0:255];

    int tests = 0;
    int fails = 0;
    int row   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .WAIT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .freeze_if  (freeze_if),
        .freeze_pipe(freeze_pipe)
    );

    // Word-addressed SRAM model, preloaded whenever reset is applied.
    always @(posedge clk) begin
        if (rst) begin
            tb_mem[4]  <= D10;
            tb_mem[8]  <= D20;
            tb_mem[12] <= D30;
            tb_mem[32] <= D80;
            tb_mem[64] <= D100;
        end else if (sram_en && sram_we) begin
            tb_mem[sram_addr[9:2]] <= sram_wdata;
        end
    end
    assign sram_rdata = tb_mem[sram_addr[9:2]];

    typedef struct {
        logic        rst, ireq;
        logic [31:0] ia;
        logic        fl, rd, wr;
        logic [31:0] ma, wd;
        logic        en, we;
        logic [31:0] sa, sw;
        logic        ifr;
        logic [31:0] ifd;
        logic        mr;
        logic [31:0] md;
        logic        fif, fp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic r, input logic ireq, input logic [31:0] ia,
                       input logic fl, input logic rd, input logic wr,
                       input logic [31:0] ma, input logic [31:0] wd,
                       input logic en, input logic we, input logic [31:0] sa,
                       input logic [31:0] sw, input logic ifr, input logic [31:0] ifd,
                       input logic mr, input logic [31:0] md, input logic fif, input logic fp);
        vec_t v;
        v.rst = r;  v.ireq = ireq; v.ia = ia; v.fl = fl; v.rd = rd; v.wr = wr;
        v.ma = ma;  v.wd = wd;     v.en = en; v.we = we; v.sa = sa; v.sw = sw;
        v.ifr = ifr; v.ifd = ifd;  v.mr = mr; v.md = md; v.fif = fif; v.fp = fp;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    initial begin
        int mr_cnt;
        int mr_cycle;
        int lat;
        logic early_if;
        logic got_if;

        // Idle after reset
        add(3, 0,0,32'h0,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,32'h0,0,32'h0, 0,0);
        // IF fetch of 0x10
        add(1, 0,1,32'h10,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,32'h0,0,32'h0, 1,0);
        add(4, 0,1,32'h10,0,0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 0,32'h0,0,32'h0, 1,0);
        add(1, 0,1,32'h10,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,D10,0,32'h0, 0,0);
        add(1, 0,0,32'h0,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D10,0,32'h0, 0,0);
        // IF and MEM read together: MEM first, then IF
        add(1, 0,1,32'h20,0,1,0,32'h100,32'h0, 0,0,32'h0,32'h0, 0,D10,0,32'h0, 1,1);
        add(4, 0,1,32'h20,0,1,0,32'h100,32'h0, 1,0,32'h100,32'h0, 0,D10,0,32'h0, 1,1);
        add(1, 0,1,32'h20,0,1,0,32'h100,32'h0, 0,0,32'h0,32'h0, 0,D10,1,D100, 1,0);
        add(1, 0,1,32'h20,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D10,0,D100, 1,0);
        add(4, 0,1,32'h20,0,0,0,32'h0,32'h0, 1,0,32'h20,32'h0, 0,D10,0,D100, 1,0);
        add(1, 0,1,32'h20,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,D20,0,D100, 0,0);
        add(1, 0,0,32'h0,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D20,0,D100, 0,0);
        // MEM write then read-back of the same address
        add(1, 0,0,32'h0,0,0,1,32'h100,DBEEF, 0,0,32'h0,32'h0, 0,D20,0,D100, 1,1);
        add(4, 0,0,32'h0,0,0,1,32'h100,DBEEF, 1,1,32'h100,DBEEF, 0,D20,0,D100, 1,1);
        add(1, 0,0,32'h0,0,0,1,32'h100,DBEEF, 0,0,32'h0,32'h0, 0,D20,1,D100, 0,0);
        add(1, 0,0,32'h0,0,1,0,32'h100,32'h0, 0,0,32'h0,32'h0, 0,D20,0,D100, 1,1);
        add(4, 0,0,32'h0,0,1,0,32'h100,32'h0, 1,0,32'h100,32'h0, 0,D20,0,D100, 1,1);
        add(1, 0,0,32'h0,0,1,0,32'h100,32'h0, 0,0,32'h0,32'h0, 0,D20,1,DBEEF, 0,0);
        add(1, 0,0,32'h0,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D20,0,DBEEF, 0,0);
        // Flush during IF BUSY, then a new fetch of 0x80
        add(1, 0,1,32'h30,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D20,0,DBEEF, 1,0);
        add(1, 0,1,32'h30,0,0,0,32'h0,32'h0, 1,0,32'h30,32'h0, 0,D20,0,DBEEF, 1,0);
        add(1, 0,1,32'h30,1,0,0,32'h0,32'h0, 1,0,32'h30,32'h0, 0,D20,0,DBEEF, 1,0);
        add(1, 0,1,32'h80,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D20,0,DBEEF, 1,0);
        add(4, 0,1,32'h80,0,0,0,32'h0,32'h0, 1,0,32'h80,32'h0, 0,D20,0,DBEEF, 1,0);
        add(1, 0,1,32'h80,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 1,D80,0,DBEEF, 0,0);
        add(1, 0,0,32'h0,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D80,0,DBEEF, 0,0);
        // Flush in the IF response cycle suppresses if_ready
        add(1, 0,1,32'h10,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D80,0,DBEEF, 1,0);
        add(4, 0,1,32'h10,0,0,0,32'h0,32'h0, 1,0,32'h10,32'h0, 0,D80,0,DBEEF, 1,0);
        add(1, 0,1,32'h10,1,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D10,0,DBEEF, 1,0);
        add(1, 0,0,32'h0,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D10,0,DBEEF, 0,0);
        // Flush has no effect on a MEM read
        add(2, 0,0,32'h0,0,1,0,32'h10,32'h0, 0,0,32'h0,32'h0, 0,D10,0,DBEEF, 1,1);
        vecs[vecs.size()-1].en = 1'b1; vecs[vecs.size()-1].sa = 32'h10;
        add(1, 0,0,32'h0,1,1,0,32'h10,32'h0, 1,0,32'h10,32'h0, 0,D10,0,DBEEF, 1,1);
        add(2, 0,0,32'h0,0,1,0,32'h10,32'h0, 1,0,32'h10,32'h0, 0,D10,0,DBEEF, 1,1);
        add(1, 0,0,32'h0,0,1,0,32'h10,32'h0, 0,0,32'h0,32'h0, 0,D10,1,D10, 0,0);
        add(1, 0,0,32'h0,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,D10,0,D10, 0,0);
        // Reset in the middle of a MEM read
        add(1, 0,0,32'h0,0,1,0,32'h20,32'h0, 0,0,32'h0,32'h0, 0,D10,0,D10, 1,1);
        add(1, 0,0,32'h0,0,1,0,32'h20,32'h0, 1,0,32'h20,32'h0, 0,D10,0,D10, 1,1);
        add(1, 1,0,32'h0,0,1,0,32'h20,32'h0, 1,0,32'h20,32'h0, 0,D10,0,D10, 1,1);
        add(2, 0,0,32'h0,0,0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,32'h0,0,32'h0, 0,0);

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            row       = i;
            rst       = vecs[i].rst;
            if_req    = vecs[i].ireq;
            if_addr   = vecs[i].ia;
            if_flush  = vecs[i].fl;
            mem_rd_en = vecs[i].rd;
            mem_wr_en = vecs[i].wr;
            mem_addr  = vecs[i].ma;
            mem_wdata = vecs[i].wd;
            @(negedge clk);
            chk("sram_en", {31'b0, sram_en}, {31'b0, vecs[i].en});
            chk("sram_we", {31'b0, sram_we}, {31'b0, vecs[i].we});
            if (vecs[i].en) chk("sram_addr", sram_addr, vecs[i].sa);
            if (vecs[i].we) chk("sram_wdata", sram_wdata, vecs[i].sw);
            chk("if_ready", {31'b0, if_ready}, {31'b0, vecs[i].ifr});
            chk("if_rdata", if_rdata, vecs[i].ifd);
            chk("mem_ready", {31'b0, mem_ready}, {31'b0, vecs[i].mr});
            chk("mem_rdata", mem_rdata, vecs[i].md);
            chk("freeze_if", {31'b0, freeze_if}, {31'b0, vecs[i].fif});
            chk("freeze_pipe", {31'b0, freeze_pipe}, {31'b0, vecs[i].fp});
            $display("[TB] row %0d: en=%0b we=%0b addr=%h if_ready=%0b mem_ready=%0b",
                     i, sram_en, sram_we, sram_addr, if_ready, mem_ready);
            @(posedge clk);
            #1;
        end

        // MEM back-to-back reads keep a pending fetch waiting
        row = vecs.size();
        drive_idle();
        if_req = 1'b1; if_addr = 32'h10;
        mem_rd_en = 1'b1; mem_addr = 32'h20;
        mr_cnt = 0; mr_cycle = -1; early_if = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if_ready) early_if = 1'b1;
            if (mem_ready) begin
                mr_cnt++;
                chk("starve_mem_rdata", mem_rdata, D20);
                if (mr_cnt == 2) begin
                    mr_cycle = c;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("starve_mem_count", mr_cnt, 2);
        chk("starve_second_ready_cycle", mr_cycle, 11);
        chk("starve_no_if_ready", {31'b0, early_if}, 32'd0);
        $display("[TB] starvation: %0d mem reads, second at cycle %0d", mr_cnt, mr_cycle);

        @(posedge clk);
        #1;
        mem_rd_en = 1'b0;
        lat = 0; got_if = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (if_ready) begin
                got_if = 1'b1;
                lat = c;
                chk("starve_if_rdata", if_rdata, D10);
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("starve_if_ready_seen", {31'b0, got_if}, 32'd1);
        chk("starve_if_latency", lat, 6);
        $display("[TB] starvation: fetch completed %0d cycles after last mem_ready", lat);

        @(posedge clk);
        #1;
        drive_idle();
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
